matrix_stream_loader: RTL and testbench
=======================================

// Module: matrix_stream_loader
// PURPOSE
// - Upstream front end of the matrix inversion pipeline. Deserialises a valid/ready stream of W-bit elements into the
//   flattened N*N matrix bus that feeds the inversion top.
// - Checks frame framing and symmetry, which LDL needs. Issues a one-cycle start pulse per good matrix.
// - Holds the matrix stable and refuses new data until the pipeline reports done.
// PARAMETERS
// - N      3   matrix dimension (N >= 2)
// - W      8   element width in bits
// PORTS
// - clk         in   1        clock; all state updates on rising edge
// - rst_n       in   1        asynchronous, active-low reset
// - s_valid     in   1        upstream element valid
// - s_ready     out  1        loader can accept an element
// - s_data      in   W        element value, row-major order, (0,0) first
// - s_last      in   1        marks the final element of a frame
// - matrix_out  out  W*N*N    element (r,c) at bits [W*(r*N+c) +: W]; feeds the inversion top matrix_in
// - start       out  1        one-cycle pulse; matrix_out is valid and stable
// - done_in     in   1        pipeline done level; only its rising edge is used
// - busy        out  1        high from start pulse until done_in rising edge
// - frame_err   out  1        one-cycle pulse on a framing violation
// - sym_err     out  1        one-cycle pulse when a complete frame is not symmetric
// BEHAVIOUR
// - Reset values: s_ready=0, matrix_out=0, start=0, busy=0, frame_err=0, sym_err=0.
//   Internal state: state=LOAD, idx=0, done_q=0.
// - s_ready is combinational from state: 1 in LOAD and DRAIN, 0 in CHECK and WAIT.
//   It is therefore 1 from the first edge after reset release.
// - Beat = s_valid & s_ready at a rising edge. idx is a counter of width $clog2(N*N), range 0..N*N-1.
// - LOAD: on a beat, write s_data into slot idx.
//   - s_last=1 and idx<N*N-1 (early last): frame_err pulse, idx<=0, stay LOAD. Partial data is discarded;
//     the matrix register is not cleared.
//   - idx==N*N-1 and s_last=1: idx<=0, go CHECK.
//   - idx==N*N-1 and s_last=0 (missing last): frame_err pulse, idx<=0, go DRAIN.
//   - Otherwise: idx<=idx+1.
// - DRAIN: accept and discard beats until a beat with s_last=1, then go LOAD. matrix_out is not written.
// - CHECK: lasts exactly one cycle. Symmetry is evaluated combinationally: every (r,c) equals (c,r) for r<c.
//   - Symmetric: start<=1 and busy<=1 for the next cycle, go WAIT.
//   - Asymmetric: sym_err<=1 for one cycle, go LOAD. No start is issued.
// - Latency: start is high in the second cycle after the edge that accepts the last beat.
// - WAIT: matrix_out is frozen. done_q registers done_in every cycle.
//   - Rising edge (done_in & ~done_q): busy<=0, go LOAD. The next beat is accepted in the following cycle.
//   - done_in already high on WAIT entry does not count; a fresh 0->1 transition is required.
// - done_in edges outside WAIT are ignored, but done_q still tracks done_in.
// - start, frame_err and sym_err are registered pulses, each exactly one cycle wide.
// - s_valid=0 holds all state. Data values are not interpreted, apart from the equality compare.
// - rst_n low at any time forces all reset values immediately, including mid-frame and in WAIT.
//   After release, the loader waits in LOAD with idx=0.
// STRUCTURE
// - Shared package matrix_pkg:
//   - state enum {LOAD, DRAIN, CHECK, WAIT}
//   - localparam NN=N*N and IDX_W=$clog2(NN)
//   - function elem_lsb(r,c) = W*(r*N+c)
// - Sub-module sym_check #(N,W): purely combinational. Input is the flattened matrix; output is is_sym.
//   Used once, in CHECK.
// - Top level holds the FSM, idx counter, matrix register, done edge detector and pulse registers.
// TESTING (N=3, W=8)
// 1. Reset, then stream 4,2,1, 2,5,3, 1,3,6 with last on beat 9.
//    -> matrix_out=0x060301030502010204, start pulse 2 cycles after beat 9, busy=1, s_ready=0.
// 2. In WAIT, hold done_in=1 from WAIT entry, drop it, raise it.
//    -> busy clears only on the second rise; next frame accepted 1 cycle after.
// 3. Stream 1..9 (asymmetric) with last on beat 9.
//    -> sym_err pulse, no start, s_ready=1 next cycle, busy=0.
// 4. s_last on beat 5, then a full symmetric frame.
//    -> frame_err on beat 5; new frame loads from slot 0 and starts normally.
// 5. 9 beats without last, then 2 beats with last on the second.
//    -> frame_err after beat 9; DRAIN discards 2 beats; matrix_out unchanged; then LOAD.
// 6. Random s_valid gaps during a frame, and rst_n pulsed low after beat 6 or while in WAIT.
//    -> gaps change nothing; reset forces all outputs 0 and idx 0; a following full frame starts correctly.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix stream loader: FSM state encoding,
// default matrix geometry and the flattened-bus element offset helper.
package matrix_pkg;

  localparam int MAT_N = 3;
  localparam int MAT_W = 8;
  localparam int NN    = MAT_N * MAT_N;
  localparam int IDX_W = $clog2(NN);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    CHECK = 2'd2,
    WAIT  = 2'd3
  } state_e;

  function automatic int elem_lsb(input int r, input int c);
    return MAT_W * (r * MAT_N + c);
  endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Valid/ready element stream into the loader; master is the upstream producer.
interface matrix_stream_loader_if #(
  parameter int W = 8
) ();

  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/sym_check.sv
// Combinational symmetry test on a flattened row-major N*N matrix.
module sym_check #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic [W*N*N-1:0] matrix,
  output logic             is_sym
);

  // Compare every upper-triangle element against its mirror.
  always_comb begin
    is_sym = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int c = r + 1; c < N; c++) begin
        if (matrix[W*(r*N+c) +: W] != matrix[W*(c*N+r) +: W]) begin
          is_sym = 1'b0;
        end else begin
          is_sym = is_sym;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_stream_loader.sv
// Deserialises an element stream into a flattened N*N matrix, checks framing and
// symmetry, then issues start and holds the matrix until the pipeline reports done.
module matrix_stream_loader
  import matrix_pkg::*;
#(
  parameter int N = MAT_N,
  parameter int W = MAT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_stream_loader_if.slave s,
  output logic [W*N*N-1:0]     matrix_out,
  output logic                 start,
  input  logic                 done_in,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 sym_err
);

  localparam int FRAME_LEN = N * N;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [W*N*N-1:0]   mat_q, mat_d;
  logic               done_q, done_d;
  logic               init_q, init_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               ferr_q, ferr_d;
  logic               serr_q, serr_d;
  logic               ready_s;
  logic               beat_s;
  logic               is_sym_s;

  // init_q keeps s_ready low until the first edge after reset release.
  assign ready_s    = init_q & ((state_q == LOAD) | (state_q == DRAIN));
  assign beat_s     = s.s_valid & ready_s;
  assign s.s_ready  = ready_s;
  assign matrix_out = mat_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign frame_err  = ferr_q;
  assign sym_err    = serr_q;

  sym_check #(.N(N), .W(W)) u_sym_check (
    .matrix (mat_q),
    .is_sym (is_sym_s)
  );

  // Next-state logic for the loader FSM, slot counter, matrix and pulses.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mat_d   = mat_q;
    done_d  = done_in;
    init_d  = 1'b1;
    start_d = 1'b0;
    busy_d  = busy_q;
    ferr_d  = 1'b0;
    serr_d  = 1'b0;
    case (state_q)
      LOAD: begin
        if (beat_s) begin
          for (int k = 0; k < FRAME_LEN; k++) begin
            if (idx_q == CNT_W'(k)) begin
              mat_d[k*W +: W] = s.s_data;
            end else begin
              mat_d[k*W +: W] = mat_d[k*W +: W];
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d = {CNT_W{1'b0}};
            if (s.s_last) begin
              state_d = CHECK;
            end else begin
              ferr_d  = 1'b1;
              state_d = DRAIN;
            end
          end else if (s.s_last) begin
            // Early last: partial frame is abandoned, loaded slots stay as written.
            ferr_d = 1'b1;
            idx_d  = {CNT_W{1'b0}};
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      DRAIN: begin
        if (beat_s && s.s_last) begin
          state_d = LOAD;
        end else begin
          state_d = DRAIN;
        end
      end
      CHECK: begin
        if (is_sym_s) begin
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = WAIT;
        end else begin
          serr_d  = 1'b1;
          state_d = LOAD;
        end
      end
      WAIT: begin
        // Only a fresh 0->1 transition of done_in releases the matrix.
        if (done_in && !done_q) begin
          busy_d  = 1'b0;
          state_d = LOAD;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= {CNT_W{1'b0}};
      mat_q   <= {(W*N*N){1'b0}};
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mat_q   <= mat_d;
      done_q  <= done_d;
      init_q  <= init_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      serr_q  <= serr_d;
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed/randomised bench for matrix_stream_loader (N=3, W=8) with a frame-level
// reference model of the expected matrix register and symmetry outcome.
module tb_matrix_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        done_in;
  logic [71:0] matrix_out;
  logic        start, busy, frame_err, sym_err;

  int tests  = 0;
  int failed = 0;

  logic [7:0] exp_mat [9];
  logic [7:0] fr [9];

  matrix_stream_loader_if #(.W(8)) sif ();

  matrix_stream_loader #(.N(3), .W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (sif),
    .matrix_out (matrix_out),
    .start      (start),
    .done_in    (done_in),
    .busy       (busy),
    .frame_err  (frame_err),
    .sym_err    (sym_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] pack(input logic [7:0] a [9]);
    logic [71:0] p = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[matrix_pkg::elem_lsb(r, c) +: 8] = a[r*3+c];
    return p;
  endfunction

  function automatic bit ref_sym(input logic [7:0] a [9]);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (a[r*3+c] != a[c*3+r]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic gen(output logic [7:0] a [9], input bit sym);
    int r, c;
    for (int i = 0; i < 3; i++)
      for (int j = i; j < 3; j++) begin
        a[i*3+j] = 8'($urandom);
        a[j*3+i] = a[i*3+j];
      end
    if (!sym) begin
      r = $urandom_range(0, 1);
      c = $urandom_range(r + 1, 2);
      a[r*3+c] = a[c*3+r] ^ 8'($urandom_range(1, 255));
    end
  endtask

  // Offers one element (optionally after random idle cycles) and returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input bit gaps);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        sif.s_valid = 1'b0;
        sif.s_data  = 8'($urandom);
        sif.s_last  = 1'($urandom);
        tick();
      end
    end
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = l;
    while (sif.s_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("ready_timeout", {71'd0, sif.s_ready}, 72'd1);
    tick();
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  // Full frame, then the CHECK outcome predicted by the model; optionally completes WAIT.
  task automatic frame(input logic [7:0] a [9], input bit gaps, input bit release_wait);
    bit sym;
    for (int i = 0; i < 9; i++) begin
      send(a[i], 1'(i == 8), gaps);
      exp_mat[i] = a[i];
    end
    sym = ref_sym(a);
    chk("frm_no_early_start", {71'd0, start}, 72'd0);
    tick();
    chk("frm_start", {71'd0, start}, {71'd0, sym});
    chk("frm_sym_err", {71'd0, sym_err}, {71'd0, !sym});
    chk("frm_busy", {71'd0, busy}, {71'd0, sym});
    chk("frm_matrix", matrix_out, pack(exp_mat));
    if (sym && release_wait) begin
      done_in = 1'b0;
      tick();
      chk("frm_start_one_cycle", {71'd0, start}, 72'd0);
      done_in = 1'b1;
      tick();
      chk("frm_busy_release", {71'd0, busy}, 72'd0);
      done_in = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, {71'd0, sif.s_ready}, 72'd0);
    chk({tag, "_matrix"}, matrix_out, 72'd0);
    chk({tag, "_pulses"}, {68'd0, start, busy, frame_err, sym_err}, 72'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    done_in = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = 8'd0;
    sif.s_last  = 1'b0;
    foreach (exp_mat[i]) exp_mat[i] = 8'd0;

    // Reset values and s_ready staying low until the first edge after release.
    #12;
    check_all_zero("rst");
    #10;
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {71'd0, sif.s_ready}, 72'd0);
    tick();
    chk("ready_after_edge", {71'd0, sif.s_ready}, 72'd1);

    // Test 1: known symmetric frame.
    fr = '{8'd4, 8'd2, 8'd1, 8'd2, 8'd5, 8'd3, 8'd1, 8'd3, 8'd6};
    for (int i = 0; i < 9; i++) begin
      send(fr[i], 1'(i == 8), 1'b0);
      exp_mat[i] = fr[i];
    end
    chk("t1_start_wait", {71'd0, start}, 72'd0);
    chk("t1_ready_check", {71'd0, sif.s_ready}, 72'd0);
    done_in = 1'b1;
    tick();
    chk("t1_start", {71'd0, start}, 72'd1);
    chk("t1_busy", {71'd0, busy}, 72'd1);
    chk("t1_ready_wait", {71'd0, sif.s_ready}, 72'd0);
    chk("t1_matrix_const", matrix_out, 72'h060301030502010204);
    chk("t1_matrix_model", matrix_out, pack(exp_mat));

    // Test 2: done_in high on WAIT entry must not release.
    repeat (3) tick();
    chk("t2_start_pulse_end", {71'd0, start}, 72'd0);
    chk("t2_busy_held", {71'd0, busy}, 72'd1);
    done_in = 1'b0;
    tick();
    chk("t2_busy_after_drop", {71'd0, busy}, 72'd1);
    done_in = 1'b1;
    tick();
    chk("t2_busy_cleared", {71'd0, busy}, 72'd0);
    chk("t2_ready_again", {71'd0, sif.s_ready}, 72'd1);
    done_in = 1'b0;

    // Test 3: asymmetric 1..9.
    for (int i = 0; i < 9; i++) fr[i] = 8'(i + 1);
    frame(fr, 1'b0, 1'b1);
    chk("t3_ready_next", {71'd0, sif.s_ready}, 72'd1);
    tick();
    chk("t3_sym_err_one_cycle", {71'd0, sym_err}, 72'd0);

    // Test 4: early last on beat 5, then a full symmetric frame.
    for (int i = 0; i < 5; i++) begin
      fr[i] = 8'($urandom);
      send(fr[i], 1'(i == 4), 1'b0);
      exp_mat[i] = fr[i];
    end
    chk("t4_frame_err", {71'd0, frame_err}, 72'd1);
    tick();
    chk("t4_frame_err_one_cycle", {71'd0, frame_err}, 72'd0);
    chk("t4_partial_matrix", matrix_out, pack(exp_mat));
    gen(fr, 1'b1);
    frame(fr, 1'b0, 1'b1);

    // Test 5: missing last, DRAIN of two beats, then a normal frame.
    gen(fr, 1'b1);
    for (int i = 0; i < 9; i++) begin
      send(fr[i], 1'b0, 1'b0);
      exp_mat[i] = fr[i];
    end
    chk("t5_frame_err", {71'd0, frame_err}, 72'd1);
    send(8'hAA, 1'b0, 1'b0);
    chk("t5_frame_err_one_cycle", {71'd0, frame_err}, 72'd0);
    send(8'hBB, 1'b1, 1'b0);
    chk("t5_drain_matrix", matrix_out, pack(exp_mat));
    chk("t5_drain_no_start", {71'd0, start}, 72'd0);
    tick();
    chk("t5_no_late_start", {71'd0, start}, 72'd0);
    chk("t5_ready_load", {71'd0, sif.s_ready}, 72'd1);
    gen(fr, 1'b1);
    frame(fr, 1'b1, 1'b1);

    // Test 6: reset mid-frame after beat 6, then reset in WAIT.
    gen(fr, 1'b1);
    for (int i = 0; i < 6; i++) send(fr[i], 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst_mid");
    foreach (exp_mat[i]) exp_mat[i] = 8'd0;
    #3;
    rst_n = 1'b1;
    tick();
    chk("t6_ready_after_rst", {71'd0, sif.s_ready}, 72'd1);
    gen(fr, 1'b1);
    frame(fr, 1'b1, 1'b1);
    gen(fr, 1'b1);
    frame(fr, 1'b1, 1'b0);
    chk("t6_in_wait_busy", {71'd0, busy}, 72'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst_wait");
    foreach (exp_mat[i]) exp_mat[i] = 8'd0;
    #3;
    rst_n = 1'b1;
    tick();
    gen(fr, 1'b1);
    frame(fr, 1'b1, 1'b1);

    // Random mix of symmetric and asymmetric frames with gaps.
    for (int k = 0; k < 8; k++) begin
      gen(fr, 1'($urandom));
      frame(fr, 1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
